// File: rtl/cdc_mux_scheduler_pkg.sv
// Shared definitions for the CDC mux scheduler.
//   state_t   : scheduler FSM states (IDLE, HOLD)
//   CNT_W     : width of the hold-window counter (covers hold lengths up to 255)
//   tag_width : ceil(log2(n)), floored at 1, used to size the requester tag
package cdc_mux_scheduler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int CNT_W = 8;

  function automatic int tag_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 16; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/cdc_mux_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req        : per-requester request level
//   last_grant : index granted most recently; search starts just above it
//   grant      : index of the chosen requester (valid only when valid=1)
//   valid      : at least one request is pending
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int TAGW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [TAGW-1:0] last_grant,
  output logic [TAGW-1:0] grant,
  output logic            valid
);

  int              idx;
  logic [TAGW-1:0] idx_t;

  // Walk the offsets from farthest to nearest so the nearest pending
  // requester above last_grant is the one that sticks.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    idx_t = '0;
    for (int off = NREQ; off >= 1; off--) begin
      idx   = (int'(last_grant) + off) % NREQ;
      idx_t = TAGW'(idx);
      if (req[idx_t]) begin
        grant = idx_t;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdc_mux_scheduler.sv
// Round-robin scheduler that multiplexes NREQ requester words onto a single
// register-driven word for a fast_clk -> slow_clk synchronizer. Each granted
// word is held stable for HOLD_CYCLES cycles; tx_toggle flips once per word
// so the slow side can detect new data.
//   fast_clk  : sole clock, rising edge
//   rst_n     : synchronous active-low reset
//   req       : per-requester request level
//   req_data  : requester i payload at [i*WIDTH +: WIDTH]
//   ack       : one-hot, one-cycle acceptance pulse
//   tx_word   : {tag, payload}, straight from a register
//   tx_toggle : flips on every new tx_word
//   busy      : high during the hold window
module cdc_mux_scheduler
  import cdc_mux_scheduler_pkg::*;
#(
  parameter  int WIDTH       = 12,
  parameter  int NREQ        = 4,
  parameter  int HOLD_CYCLES = 8,
  localparam int TAGW        = tag_width(NREQ)
) (
  input  logic                  fast_clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic [TAGW+WIDTH-1:0] tx_word,
  output logic                  tx_toggle,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [TAGW-1:0]   last_grant;
  logic [TAGW-1:0]   grant;
  logic              grant_vld;
  logic              grant_fire;
  logic [WIDTH-1:0]  sel_data;

  rr_arbiter #(
    .NREQ (NREQ),
    .TAGW (TAGW)
  ) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .grant      (grant),
    .valid      (grant_vld)
  );

  // State register
  always_ff @(posedge fast_clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: HOLD spans HOLD_LOAD..0 inclusive, i.e. HOLD_CYCLES cycles
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    grant_fire = (state == IDLE) && grant_vld;
    busy       = (state == HOLD);
  end

  // Payload of the requester currently selected by the arbiter
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == TAGW'(i)) sel_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Grant edge: capture word, flip toggle, pulse ack, advance priority.
  // Everything here is registered so tx_word feeds the synchronizer cleanly.
  always_ff @(posedge fast_clk) begin
    if (!rst_n) begin
      tx_word    <= '0;
      tx_toggle  <= 1'b0;
      ack        <= '0;
      last_grant <= TAGW'(NREQ - 1);
    end else begin
      ack <= '0;
      if (grant_fire) begin
        tx_word    <= {grant, sel_data};
        tx_toggle  <= ~tx_toggle;
        ack        <= NREQ'(1) << grant;
        last_grant <= grant;
      end
    end
  end

endmodule
